// File: rtl/axil_regbank_if.sv
// AXI4-Lite slave-side bundle for axil_regbank: the five channels grouped behind
// master/slave modports so the bank and its initiator share one declaration.
interface axil_regbank_if #(
   parameter int DW = 32,
   parameter int AW = 8
);
   logic [AW-1:0]   S_AXI_AWADDR;
   logic [2:0]      S_AXI_AWPROT;
   logic            S_AXI_AWVALID;
   logic            S_AXI_AWREADY;
   logic [DW-1:0]   S_AXI_WDATA;
   logic [DW/8-1:0] S_AXI_WSTRB;
   logic            S_AXI_WVALID;
   logic            S_AXI_WREADY;
   logic [1:0]      S_AXI_BRESP;
   logic            S_AXI_BVALID;
   logic            S_AXI_BREADY;
   logic [AW-1:0]   S_AXI_ARADDR;
   logic [2:0]      S_AXI_ARPROT;
   logic            S_AXI_ARVALID;
   logic            S_AXI_ARREADY;
   logic [DW-1:0]   S_AXI_RDATA;
   logic [1:0]      S_AXI_RRESP;
   logic            S_AXI_RVALID;
   logic            S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );
endinterface

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite register bank with byte strobes, AW/W in any order and SLVERR decode.
// Define AXIL_REGBANK_WR_PULSE_EN to add wr_pulse_o, a one-cycle per-register write strobe.
module axil_regbank #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8,
   parameter int NUM_REGS           = 8,
   parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                                   ACLK,
   input  logic                                   ARESET,
   axil_regbank_if.slave                          s_axi,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o
`ifdef AXIL_REGBANK_WR_PULSE_EN
   ,
   output logic [NUM_REGS-1:0]                    wr_pulse_o
`endif
);
   localparam int DW       = C_S_AXI_DATA_WIDTH;
   localparam int NB       = DW / 8;
   localparam int ADDR_LSB = $clog2(NB);
   localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t            r_wstate, w_wstate_next;
   rstate_t            r_rstate, w_rstate_next;
   logic               r_rdy_en;
   logic               r_aw_held, r_w_held;
   logic [IDX_W-1:0]   r_aw_idx;
   logic [DW-1:0]      r_wdata;
   logic [NB-1:0]      r_wstrb;
   logic [1:0]         r_bresp;
   logic [DW-1:0]      r_rdata;
   logic [1:0]         r_rresp;
   logic [DW-1:0]      r_regs [NUM_REGS];

   logic               w_awready, w_wready, w_bvalid, w_commit;
   logic               w_arready, w_rvalid;
   logic               w_aw_hs, w_w_hs, w_ar_hs;
   logic [NUM_REGS-1:0] w_wr_sel;
   logic               w_wr_hit;
   logic [IDX_W-1:0]   w_ar_idx;
   logic [DW-1:0]      w_rd_data;
   logic               w_rd_hit;
   logic               w_unused_ok;

   assign w_unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};

   // READYs are held off until the first clock after reset release.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_rdy_en <= 1'b0;
      else        r_rdy_en <= 1'b1;
   end

   // ---------------- write channel ----------------
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_wstate <= W_IDLE;
      else        r_wstate <= w_wstate_next;
   end

   always_comb begin
      w_wstate_next = r_wstate;
      w_awready     = 1'b0;
      w_wready      = 1'b0;
      w_bvalid      = 1'b0;
      w_commit      = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            w_awready = r_rdy_en && !r_aw_held;
            w_wready  = r_rdy_en && !r_w_held;
            if (r_aw_held && r_w_held) begin
               w_commit      = 1'b1;
               w_wstate_next = W_RESP;
            end
         end
         W_RESP: begin
            w_bvalid = 1'b1;
            if (s_axi.S_AXI_BREADY) w_wstate_next = W_IDLE;
         end
      endcase
   end

   assign w_aw_hs = w_awready && s_axi.S_AXI_AWVALID;
   assign w_w_hs  = w_wready  && s_axi.S_AXI_WVALID;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_aw_idx  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else if (w_commit) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axi.S_AXI_WDATA;
            r_wstrb  <= s_axi.S_AXI_WSTRB;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         assign w_wr_sel[gi]            = (r_aw_idx == IDX_W'(gi));
         assign regs_o[gi*DW +: DW]     = r_regs[gi];
      end
   endgenerate

   // No select bit set means the captured index lies beyond the bank.
   assign w_wr_hit = |w_wr_sel;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
      end else if (w_commit) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            for (int b = 0; b < NB; b++) begin
               if (w_wr_sel[k] && r_wstrb[b]) r_regs[k][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)        r_bresp <= RESP_OKAY;
      else if (w_commit) r_bresp <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
   end

`ifdef AXIL_REGBANK_WR_PULSE_EN
   logic [NUM_REGS-1:0] r_wr_pulse;
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_wr_pulse <= '0;
      else        r_wr_pulse <= w_commit ? w_wr_sel : '0;
   end
   assign wr_pulse_o = r_wr_pulse;
`endif

   // ---------------- read channel ----------------
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_rstate <= R_IDLE;
      else        r_rstate <= w_rstate_next;
   end

   always_comb begin
      w_rstate_next = r_rstate;
      w_arready     = 1'b0;
      w_rvalid      = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            w_arready = r_rdy_en;
            if (r_rdy_en && s_axi.S_AXI_ARVALID) w_rstate_next = R_DATA;
         end
         R_DATA: begin
            w_rvalid = 1'b1;
            if (s_axi.S_AXI_RREADY) w_rstate_next = R_IDLE;
         end
      endcase
   end

   assign w_ar_hs  = w_arready && s_axi.S_AXI_ARVALID;
   assign w_ar_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

   always_comb begin
      w_rd_data = '0;
      w_rd_hit  = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (w_ar_idx == IDX_W'(k)) begin
            w_rd_data = r_regs[k];
            w_rd_hit  = 1'b1;
         end
      end
   end

   // Sampling r_regs on the AR edge gives pre-write data when a write commits on the same edge.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rdata <= w_rd_data;
         r_rresp <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
   end

   assign s_axi.S_AXI_AWREADY = w_awready;
   assign s_axi.S_AXI_WREADY  = w_wready;
   assign s_axi.S_AXI_BVALID  = w_bvalid;
   assign s_axi.S_AXI_BRESP   = r_bresp;
   assign s_axi.S_AXI_ARREADY = w_arready;
   assign s_axi.S_AXI_RVALID  = w_rvalid;
   assign s_axi.S_AXI_RDATA   = r_rdata;
   assign s_axi.S_AXI_RRESP   = r_rresp;
endmodule

// File: tb/tb_axil_regbank.sv
// Testbench for axil_regbank: directed literal cases plus concurrent random traffic,
// checked every cycle against a queue-based transaction model.
module tb_axil_regbank;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NR = 8;
   localparam logic [DW-1:0] RST_VAL = '0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NR*DW-1:0] regs_o;
`ifdef AXIL_REGBANK_WR_PULSE_EN
   logic [NR-1:0] wr_pulse_o;
`endif

   axil_regbank_if #(.DW(DW), .AW(AW)) axi();

   axil_regbank #(
      .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VAL(RST_VAL)
   ) dut (
      .ACLK(clk),
      .ARESET(rst),
      .s_axi(axi),
      .regs_o(regs_o)
`ifdef AXIL_REGBANK_WR_PULSE_EN
      ,
      .wr_pulse_o(wr_pulse_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: handshake never happened, got none expected one at %0t", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0]   m_regs [NR];
   logic [DW+1:0]   rq [$];
   logic [1:0]      bq [$];
   bit              have_aw, have_w, both_held, cm_pend;
   logic [AW-1:0]   aw_addr;
   logic [DW-1:0]   w_data, cm_data;
   logic [DW/8-1:0] w_strb, cm_strb;
   int              cm_idx, since_rst;
   logic [NR-1:0]   exp_pulse;

   function automatic logic [NR*DW-1:0] model_flat();
      logic [NR*DW-1:0] v;
      for (int k = 0; k < NR; k++) v[k*DW +: DW] = m_regs[k];
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < NR; k++) m_regs[k] = RST_VAL;
         rq.delete();
         bq.delete();
         have_aw = 0; have_w = 0; both_held = 0; cm_pend = 0; since_rst = 0;
      end else begin
         bit rdy;
         int idx;
         if (since_rst < 10) since_rst++;
         exp_pulse = '0;
         // A write whose AW and W were both held commits one edge later.
         if (cm_pend) begin
            if (cm_idx < NR) begin
               for (int b = 0; b < DW/8; b++)
                  if (cm_strb[b]) m_regs[cm_idx][8*b +: 8] = cm_data[8*b +: 8];
               exp_pulse[cm_idx] = 1'b1;
               bq.push_back(2'b00);
            end else begin
               bq.push_back(2'b10);
            end
            cm_pend = 0;
         end
         if (both_held) begin
            cm_pend = 1; cm_idx = int'(aw_addr) / (DW/8); cm_data = w_data; cm_strb = w_strb;
            both_held = 0; have_aw = 0; have_w = 0;
         end
         rdy = (since_rst >= 2);
         chk("regs_o", regs_o, model_flat());
         chk("awready", axi.S_AXI_AWREADY, rdy && !have_aw && !cm_pend && bq.size() == 0);
         chk("wready", axi.S_AXI_WREADY, rdy && !have_w && !cm_pend && bq.size() == 0);
         chk("arready", axi.S_AXI_ARREADY, rdy && rq.size() == 0);
         chk("bvalid", axi.S_AXI_BVALID, bq.size() != 0);
         if (axi.S_AXI_BVALID && bq.size() != 0) chk("bresp", axi.S_AXI_BRESP, bq[0]);
         chk("rvalid", axi.S_AXI_RVALID, rq.size() != 0);
         if (axi.S_AXI_RVALID && rq.size() != 0) begin
            chk("rdata", axi.S_AXI_RDATA, rq[0][DW+1:2]);
            chk("rresp", axi.S_AXI_RRESP, rq[0][1:0]);
         end
`ifdef AXIL_REGBANK_WR_PULSE_EN
         chk("wr_pulse", wr_pulse_o, exp_pulse);
`endif
         // Handshakes that the coming edge will complete.
         if (axi.S_AXI_AWVALID && axi.S_AXI_AWREADY) begin have_aw = 1; aw_addr = axi.S_AXI_AWADDR; end
         if (axi.S_AXI_WVALID && axi.S_AXI_WREADY) begin
            have_w = 1; w_data = axi.S_AXI_WDATA; w_strb = axi.S_AXI_WSTRB;
         end
         if (have_aw && have_w) both_held = 1;
         if (axi.S_AXI_ARVALID && axi.S_AXI_ARREADY) begin
            idx = int'(axi.S_AXI_ARADDR) / (DW/8);
            if (idx < NR) rq.push_back({m_regs[idx], 2'b00});
            else          rq.push_back({{DW{1'b0}}, 2'b10});
         end
         if (axi.S_AXI_BVALID && axi.S_AXI_BREADY && bq.size() != 0) void'(bq.pop_front());
         if (axi.S_AXI_RVALID && axi.S_AXI_RREADY && rq.size() != 0) void'(rq.pop_front());
      end
   end

   // ---------------- bus tasks ----------------
   task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [DW/8-1:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int cyc = 0;
      resp = 2'b11;
      while (!(aw_done && w_done)) begin
         axi.S_AXI_AWADDR  = addr;
         axi.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
         axi.S_AXI_WDATA   = data;
         axi.S_AXI_WSTRB   = strb;
         axi.S_AXI_WVALID  = !w_done && (cyc >= w_dly);
         @(negedge clk);
         aw_hs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
         w_hs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
         @(posedge clk); #1;
         aw_done = aw_done || aw_hs;
         w_done  = w_done || w_hs;
         cyc++;
         if (cyc > 100 && !(aw_done && w_done)) begin timeout_fail("write_addr_data"); break; end
      end
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
      cyc = 0;
      while (1) begin
         axi.S_AXI_BREADY = (cyc >= b_dly);
         @(negedge clk);
         if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
            resp = axi.S_AXI_BRESP;
            @(posedge clk); #1;
            axi.S_AXI_BREADY = 1'b0;
            break;
         end
         @(posedge clk); #1;
         cyc++;
         if (cyc > 100) begin timeout_fail("write_resp"); axi.S_AXI_BREADY = 1'b0; break; end
      end
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                           output logic [DW-1:0] data, output logic [1:0] resp);
      bit done = 0;
      int cyc = 0;
      data = '0;
      resp = 2'b11;
      while (!done) begin
         axi.S_AXI_ARADDR  = addr;
         axi.S_AXI_ARVALID = (cyc >= ar_dly);
         @(negedge clk);
         done = axi.S_AXI_ARVALID && axi.S_AXI_ARREADY;
         @(posedge clk); #1;
         cyc++;
         if (cyc > 100 && !done) begin timeout_fail("read_addr"); break; end
      end
      axi.S_AXI_ARVALID = 1'b0;
      cyc = 0;
      while (1) begin
         axi.S_AXI_RREADY = (cyc >= r_dly);
         @(negedge clk);
         if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
            data = axi.S_AXI_RDATA;
            resp = axi.S_AXI_RRESP;
            @(posedge clk); #1;
            axi.S_AXI_RREADY = 1'b0;
            break;
         end
         @(posedge clk); #1;
         cyc++;
         if (cyc > 100) begin timeout_fail("read_data"); axi.S_AXI_RREADY = 1'b0; break; end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0]    resp, rresp;
      logic [DW-1:0] rdata;
      bit            hs;
      axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
      axi.S_AXI_BREADY = 1'b0;
      axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
      axi.S_AXI_RREADY = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", axi.S_AXI_AWREADY, 0);
      chk("rst_wready", axi.S_AXI_WREADY, 0);
      chk("rst_arready", axi.S_AXI_ARREADY, 0);
      chk("rst_bvalid", axi.S_AXI_BVALID, 0);
      chk("rst_rvalid", axi.S_AXI_RVALID, 0);
      chk("rst_rdata", axi.S_AXI_RDATA, 0);
      chk("rst_regs", regs_o, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Fill registers with 1..8 and read them back.
      for (int i = 0; i < NR; i++) begin
         axi_write(AW'(i*4), DW'(i+1), 4'hF, 0, 0, 0, resp);
         chk("fill_bresp", resp, 2'b00);
      end
      for (int i = 0; i < NR; i++) begin
         axi_read(AW'(i*4), 0, 0, rdata, rresp);
         chk("fill_rdata", rdata, DW'(i+1));
         chk("fill_rresp", rresp, 2'b00);
      end
      chk("regs_lo", regs_o[31:0], 32'h1);
      chk("regs_hi", regs_o[255:224], 32'h8);

      // Byte strobes.
      axi_write(8'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp);
      axi_write(8'h05, 32'h1234_5678, 4'b0101, 0, 0, 0, resp);
      axi_read(8'h04, 0, 0, rdata, rresp);
      chk("strobe_rdata", rdata, 32'hFF34_FF78);

      // AW/W ordering and a stalled B channel.
      axi_write(8'h08, 32'hA1, 4'hF, 3, 0, 0, resp);
      chk("w_first_bresp", resp, 2'b00);
      axi_write(8'h10, 32'hB2, 4'hF, 0, 3, 0, resp);
      chk("aw_first_bresp", resp, 2'b00);
      axi_write(8'h14, 32'hC3, 4'hF, 0, 0, 5, resp);
      chk("same_cycle_bresp", resp, 2'b00);
      axi_read(8'h08, 0, 2, rdata, rresp);
      chk("w_first_rdata", rdata, 32'hA1);
      axi_read(8'h10, 0, 0, rdata, rresp);
      chk("aw_first_rdata", rdata, 32'hB2);
      axi_read(8'h14, 0, 0, rdata, rresp);
      chk("same_cycle_rdata", rdata, 32'hC3);

      // Out of range.
      axi_write(8'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp);
      chk("oor_bresp", resp, 2'b10);
      axi_read(8'h20, 0, 0, rdata, rresp);
      chk("oor_rresp", rresp, 2'b10);
      chk("oor_rdata", rdata, 0);
      chk("oor_regs", regs_o, {32'h8, 32'h7, 32'hC3, 32'hB2, 32'h4, 32'hA1, 32'hFF34_FF78, 32'h1});

      // Zero-strobe write: in range and acknowledged, contents kept.
      axi_write(8'h0C, 32'h5555_5555, 4'h0, 0, 0, 0, resp);
      chk("zero_strb_bresp", resp, 2'b00);
      chk("zero_strb_reg3", regs_o[127:96], 32'h4);

      // Reset in the middle of a write with only AW accepted.
      axi.S_AXI_AWADDR  = 8'h08;
      axi.S_AXI_AWVALID = 1'b1;
      hs = 0;
      for (int c = 0; c < 20 && !hs; c++) begin
         @(negedge clk);
         hs = axi.S_AXI_AWREADY;
         @(posedge clk); #1;
      end
      axi.S_AXI_AWVALID = 1'b0;
      if (!hs) timeout_fail("midop_aw");
      @(posedge clk); #1;
      rst = 1'b1;
      #2;
      chk("midrst_awready", axi.S_AXI_AWREADY, 0);
      chk("midrst_wready", axi.S_AXI_WREADY, 0);
      chk("midrst_arready", axi.S_AXI_ARREADY, 0);
      chk("midrst_bvalid", axi.S_AXI_BVALID, 0);
      chk("midrst_rvalid", axi.S_AXI_RVALID, 0);
      chk("midrst_rdata", axi.S_AXI_RDATA, 0);
      chk("midrst_regs", regs_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      axi_write(8'h0C, 32'h5A5A_5A5A, 4'hF, 0, 0, 0, resp);
      chk("post_rst_bresp", resp, 2'b00);
      axi_read(8'h0C, 0, 0, rdata, rresp);
      chk("post_rst_rdata", rdata, 32'h5A5A_5A5A);
      axi_read(8'h08, 0, 0, rdata, rresp);
      chk("post_rst_discard", rdata, 32'h0);

      // Concurrent random traffic, including out-of-range and unaligned addresses.
      fork
         begin
            logic [1:0]    wresp;
            logic [AW-1:0] waddr;
            for (int i = 0; i < 150; i++) begin
               waddr = ($urandom_range(0, 7) == 0) ? AW'($urandom) :
                       AW'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
               axi_write(waddr, DW'($urandom), 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), wresp);
               chk("rand_bresp", wresp, (int'(waddr) / 4 < NR) ? 2'b00 : 2'b10);
            end
         end
         begin
            logic [1:0]    rr;
            logic [DW-1:0] rd;
            logic [AW-1:0] raddr;
            for (int i = 0; i < 150; i++) begin
               raddr = AW'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
               axi_read(raddr, $urandom_range(0, 3), $urandom_range(0, 2), rd, rr);
               chk("rand_rresp", rr, (int'(raddr) / 4 < NR) ? 2'b00 : 2'b10);
            end
         end
      join

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: got simulation still running expected completion by %0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/axil_regbank.md
# axil_regbank

Parametrised AXI4-Lite slave register bank, the next generation of our fixed four-register peripheral IP. It provides NUM_REGS read/write registers of C_S_AXI_DATA_WIDTH bits, honours write strobes, accepts AW and W in either order, and returns SLVERR for out-of-range addresses. The registers are exposed to fabric logic as a flat bus. It sits behind the AXI interconnect / VIP master as the control-register front end of a custom IP.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; 32 or 64 only.
- C_S_AXI_ADDR_WIDTH, 8, byte-address width; must cover NUM_REGS*(DW/8).
- NUM_REGS, 8, number of registers; range 2..64.
- RESET_VAL, 0, reset value loaded into every register.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA  in  DW; S_AXI_WSTRB in DW/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP  out  2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA  out  DW; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
- regs_o  out  NUM_REGS*DW  register contents; register k is at bits [k*DW +: DW].

## Operation
- Decode: ADDR_LSB = log2(DW/8); index = addr >> ADDR_LSB. Index >= NUM_REGS means out of range. Low ADDR_LSB bits are ignored.
- Write channel, states W_IDLE -> W_RESP -> W_IDLE. Only one write is outstanding at a time.
  - In W_IDLE, AWREADY is high until AW is captured, and WREADY is high until W is captured. Each channel is captured independently, in either order or in the same cycle.
  - When both are held, the block commits and enters W_RESP.
  - Commit, in range: the byte lanes with WSTRB[b]=1 are updated and the other lanes are kept. BRESP=OKAY (00).
  - Commit, out of range: no register changes. BRESP=SLVERR (10).
  - In W_RESP, AWREADY=WREADY=0 and BVALID=1 until BREADY is sampled high. The block then returns to W_IDLE.
- Read channel, states R_IDLE -> R_DATA -> R_IDLE. Only one read is outstanding.
  - In R_IDLE, ARREADY=1. On handshake, RDATA is loaded with the addressed register, or 0 and RRESP=SLVERR if out of range. RVALID is set.
  - In R_DATA, ARREADY=0. RDATA and RRESP stay stable until RREADY is sampled high.
- Read and write channels run concurrently and independently.
- Read/write collision on the same register: the read returns the value present before any write that commits on the same edge as the AR handshake.
- regs_o follows the register array directly; there is no extra pipeline stage.

## Timing
- Reset values: all READY/VALID outputs 0, BRESP=RRESP=00, RDATA=0, all registers=RESET_VAL, FSMs in IDLE.
- AWREADY, WREADY and ARREADY first rise on the first rising edge after ARESET deasserts (ready-enable flop).
- Write: the last of AW/W handshakes at edge N. The register update and BVALID=1 both appear after edge N+1. regs_o shows the new value from edge N+1. The earliest next AW acceptance is the edge after BREADY is sampled.
- Read: AR handshake at edge N. RVALID and RDATA are valid after edge N+1. With RREADY held high, the next AR is accepted one cycle after the R handshake, giving 1 read per 2 cycles maximum.
- BVALID/RVALID never drop without their READY; the payload is stable while VALID is high.
- ARESET asserted mid-transaction: all state and outputs go to reset values immediately (asynchronous). Partially captured AW/W are discarded. A write already committed is not rolled back.

## Configuration
- AXIL_REGBANK_WR_PULSE_EN defined: adds output wr_pulse_o [NUM_REGS-1:0], reset 0.
  - Bit k pulses high for exactly one cycle on the commit edge of an in-range write to register k, including a write with WSTRB=0.
  - Out-of-range writes produce no pulse.
- AXIL_REGBANK_WR_PULSE_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Defaults (DW=32, NUM_REGS=8): write 0x1,0x2,...,0x8 to addr 0x00..0x1C, then read back -> each RDATA matches, RRESP=00, regs_o[31:0]=0x1 and regs_o[255:224]=0x8.
- Strobes: write 0xFFFFFFFF then 0x12345678 with WSTRB=4'b0101 to addr 0x04 -> read returns 0xFF34FF78.
- Ordering: W presented 3 cycles before AW, then AW before W, then both in the same cycle -> each gives exactly one BVALID with OKAY and the correct data. BREADY held low 5 cycles -> BVALID and BRESP stay stable, and AWREADY stays 0.
- Out of range: write to 0x20 and read 0x20 -> BRESP=10, RRESP=10, RDATA=0, all registers unchanged.
- Reset mid-op: AW accepted without W, then ARESET pulsed -> all outputs 0, registers=RESET_VAL, and a following complete write succeeds normally.
- AXIL_REGBANK_WR_PULSE_EN defined: write to 0x0C -> wr_pulse_o=8'b00001000 for one cycle, aligned with the regs_o update; write to 0x20 -> no pulse.
